// File: rtl/bcd_timer_ctrl.sv
// BCD timer run-control: IDLE/RUN/PAUSE/DONE FSM, prescaler and a DIGITS-wide
// decade counter cascade that counts up to a target or down to zero.
module bcd_timer_ctrl #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                stop,
   input  logic                clear,
   input  logic                load,
   input  logic                mode,
   input  logic [4*DIGITS-1:0] target,
   output logic [4*DIGITS-1:0] count,
   output logic [1:0]          state,
   output logic                tick,
   output logic                done,
   output logic                wrap
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e        r_state, w_state_nx;
   logic [W-1:0]  r_count, w_count_nx;
   logic [PW-1:0] r_pre, w_pre_nx;
   logic          r_mode, w_mode_nx;
   logic          r_tick, w_tick_nx;
   logic          r_done, w_done_nx;
   logic          r_wrap, w_wrap_nx;

   logic [W-1:0]  w_tgt, w_inc, w_dec, w_upd, w_term_run, w_term_start;
   logic          w_all9;

   // Digits above 9 in the target are clamped to 9 for both load and compare.
   always_comb begin : sanitise
      w_tgt = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_tgt[4*i +: 4] = (target[4*i +: 4] > 4'd9) ? 4'd9 : target[4*i +: 4];
      end
   end

   always_comb begin : incdec
      logic       v_c;
      logic       v_b;
      logic [3:0] v_d;
      v_c   = 1'b1;
      v_b   = 1'b1;
      w_inc = r_count;
      w_dec = r_count;
      for (int i = 0; i < DIGITS; i++) begin
         v_d = r_count[4*i +: 4];
         if (v_c) w_inc[4*i +: 4] = (v_d == 4'd9) ? 4'd0 : v_d + 4'd1;
         if (v_b) w_dec[4*i +: 4] = (v_d == 4'd0) ? 4'd9 : v_d - 4'd1;
         v_c = v_c & (v_d == 4'd9);
         v_b = v_b & (v_d == 4'd0);
      end
      w_all9 = v_c;
   end

   assign w_upd        = r_mode ? w_dec : w_inc;
   assign w_term_run   = r_mode ? '0 : w_tgt;
   assign w_term_start = mode ? '0 : w_tgt;

   always_comb begin : next_state
      w_state_nx = r_state;
      w_count_nx = r_count;
      w_pre_nx   = r_pre;
      w_mode_nx  = r_mode;
      w_tick_nx  = 1'b0;
      w_done_nx  = 1'b0;
      w_wrap_nx  = 1'b0;
      if (clear) begin
         w_state_nx = StIdle;
         w_count_nx = '0;
         w_pre_nx   = '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (!stop) begin
                  if (start) begin
                     w_mode_nx = mode;
                     w_pre_nx  = '0;
                     if (r_count == w_term_start) begin
                        w_state_nx = StDone;
                        w_done_nx  = 1'b1;
                     end else begin
                        w_state_nx = StRun;
                     end
                  end else if (load) begin
                     w_count_nx = mode ? w_tgt : '0;
                  end
               end
            end
            StRun: begin
               if (r_pre == PMAX) begin
                  w_pre_nx   = '0;
                  w_tick_nx  = 1'b1;
                  w_count_nx = w_upd;
                  w_wrap_nx  = ~r_mode & w_all9;
                  if (w_upd == w_term_run) begin
                     w_state_nx = StDone;
                     w_done_nx  = 1'b1;
                  end else if (stop) begin
                     w_state_nx = StPause;
                  end
               end else begin
                  // The stop cycle still counts as a RUN cycle; hold starts in PAUSE.
                  w_pre_nx = r_pre + 1'b1;
                  if (stop) w_state_nx = StPause;
               end
            end
            StPause: begin
               if (start && !stop) w_state_nx = StRun;
            end
            StDone: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_count <= '0;
         r_pre   <= '0;
         r_mode  <= 1'b0;
         r_tick  <= 1'b0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_count <= w_count_nx;
         r_pre   <= w_pre_nx;
         r_mode  <= w_mode_nx;
         r_tick  <= w_tick_nx;
         r_done  <= w_done_nx;
         r_wrap  <= w_wrap_nx;
      end
   end

   assign count = r_count;
   assign state = r_state;
   assign tick  = r_tick;
   assign done  = r_done;
   assign wrap  = r_wrap;

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Run-control FSM and prescaler that sequences a cascade of DIGITS decade (0–9) counter digits as a BCD timer.
- Supports count-up to a target and count-down from a target to zero, with start/stop/clear commands.
- Issues a one-cycle done pulse at terminal count.
- Sits between user-command logic and the seven-segment/display path, which consumes count.

Parameters:
- DIGITS, 4, number of cascaded BCD digits; count width is 4*DIGITS.
- PRESCALE, 10, clk cycles per count tick; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  level command: begin or resume counting
- stop  input  1  level command: pause counting
- clear  input  1  level command: return to IDLE and zero everything
- load  input  1  in IDLE only, preset count according to mode
- mode  input  1  0 = count up to target, 1 = count down to zero
- target  input  4*DIGITS  BCD target/preset; digit 0 at bits [3:0]
- count  output  4*DIGITS  current BCD count (registered)
- state  output  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
- tick  output  1  one-cycle pulse on the cycle count updates
- done  output  1  one-cycle pulse on entry to DONE
- wrap  output  1  one-cycle pulse when up-count rolls over from all-9s to all-0s

Behaviour:
- Reset (reset_n low, async): state IDLE, count 0, prescaler 0, mode_r 0, tick/done/wrap 0. Reset takes effect immediately, mid-run included.
- All outputs are registered. Commands are sampled at posedge.
- Command priority is clear > stop > start > load.
- Target sanitising: any target digit >9 is treated as 9 wherever target is used (load and compare).
- Terminal value: sanitised target when mode_r=0; all-zero when mode_r=1.
- IDLE:
  - load=1: count <= (mode ? target : 0).
  - start=1: mode_r <= mode, prescaler <= 0.
    - If count already equals the terminal value for that mode, go directly to DONE with a done pulse and no tick.
    - Otherwise go to RUN.
  - mode is not otherwise used in IDLE.
- RUN:
  - Prescaler counts 0..PRESCALE-1 each cycle.
  - When prescaler is at PRESCALE-1: prescaler <= 0, tick=1 that cycle, and count updates once.
  - Up count: digit 0 increments; a 9 rolls to 0 and carries into the next digit; all-9s rolls to all-0 and pulses wrap.
  - Down count: digit 0 decrements; a 0 borrows to 9 from the next digit.
  - If the updated count equals the terminal value: next state DONE, done=1 on the same edge as the final update.
  - stop=1: go to PAUSE, prescaler held. If a tick falls on the same cycle, the update and the done check still occur; DONE beats PAUSE.
  - mode changes during RUN are ignored (mode_r is latched).
- PAUSE:
  - count and prescaler hold.
  - start=1 and stop=0: resume RUN from the held prescaler value.
  - load is ignored.
- DONE: count holds; start, stop and load are ignored; only clear exits.
- clear (any state): state IDLE, count 0, prescaler 0; tick/done/wrap forced 0 that cycle.
- PRESCALE=1: tick every cycle in RUN.
- Latency:
  - start to first count change is PRESCALE cycles.
  - Up-count from 0 to target T (in decimal) takes T*PRESCALE cycles after entering RUN.

Test Plan (DIGITS=2, PRESCALE=3):
- Reset with reset_n low mid-RUN at count 37 -> count=00, state=IDLE, tick=done=0 immediately, before any clk edge.
- mode=0, target=12, clear then start -> tick every 3rd cycle; count 00→01→…→09→10→11→12; done pulses with the 12 update; state=DONE; count holds at 12 through 10 more start pulses.
- mode=1, target=10, load, start -> count 10→09→…→00; done on 00; no wrap; 30 cycles RUN→DONE.
- mode=0, target=A5 (sanitised to 95), count preset by counting: run from 98 -> 99→00 with wrap=1 on that tick; continues to 95; done.
- stop asserted one cycle after a tick, held 5 cycles, then start -> next tick occurs exactly 2 RUN cycles after resume; start+stop together in PAUSE stays PAUSE.
- start with count==terminal (mode=1, count=00) -> IDLE→DONE in one cycle, done=1, tick=0; then clear+start together -> IDLE, count 00.
